rob_alloc_ctrl: RTL and testbench

Pointer and occupancy controller for the Reorder Buffer. It shares ROB capacity between the dispatch stage, which allocates up to PIPE_WIDTH entries per cycle, and in-order commit, which retires up to PIPE_WIDTH entries per cycle. It produces the rob_rdy backpressure code and the allocated ROB tags consumed by dispatch. It sequences recovery: tail rollback on branch mispredict, and full flush on an exception at head. ROB entry storage is a separate array indexed by this block's pointers.

---
 rtl/uarch_pkg.sv | 22 ++
 rtl/rob_ptr_arith.sv | 42 ++++
 rtl/rob_alloc_ctrl.sv | 133 +++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared microarchitecture constants and types.
// ROB sizing, pointer types and the allocation-controller state enum.
package uarch_pkg;

  localparam int PIPE_WIDTH  = 2;
  localparam int ROB_ENTRIES = 32;
  localparam int ROB_TAG_W   = $clog2(ROB_ENTRIES);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ROB_TAG_W:0]   rob_ptr_t;

  typedef enum logic [1:0] {
    RUN,
    RECOVER,
    EXC_FLUSH
  } rob_ctrl_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rob_ptr_arith.sv
// Wrap-aware ROB pointer arithmetic and free-space encoding.
// Pointers carry one extra wrap bit above the index.
module rob_ptr_arith #(
  parameter int ROB_ENTRIES = 32,
  parameter int TAG_W       = $clog2(ROB_ENTRIES)
) (
  input  logic [TAG_W:0]   head_i,
  input  logic [TAG_W:0]   tail_i,
  input  logic [1:0]       n_commit_i,
  input  logic [1:0]       n_alloc_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W:0]   count_o,
  output logic [TAG_W:0]   free_o,
  output logic [TAG_W:0]   head_nxt_o,
  output logic [TAG_W:0]   tail_nxt_o,
  output logic [TAG_W:0]   tail_rec_o,
  output logic             tag_in_range_o,
  output logic [1:0]       rdy_o
);

  logic [TAG_W-1:0] off;

  assign count_o    = tail_i - head_i;
  assign free_o     = (TAG_W+1)'(ROB_ENTRIES) - count_o;
  assign head_nxt_o = head_i + (TAG_W+1)'(n_commit_i);
  assign tail_nxt_o = tail_i + (TAG_W+1)'(n_alloc_i);

  // Distance from head fixes the wrap bit of the rolled-back tail.
  assign off            = tag_i - head_i[TAG_W-1:0];
  assign tail_rec_o     = head_i + {1'b0, off} + (TAG_W+1)'(1);
  assign tag_in_range_o = {1'b0, off} < count_o;

  always_comb begin
    rdy_o = 2'b00;
    unique case (1'b1)
      (free_o >= (TAG_W+1)'(2)): rdy_o = 2'b11;
      (free_o == (TAG_W+1)'(1)): rdy_o = 2'b01;
      default:                   rdy_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB pointer/occupancy controller: allocation, in-order commit,
// mispredict tail rollback and exception-at-head flush.
module rob_alloc_ctrl
  import uarch_pkg::*;
#(
  parameter int ROB_ENTRIES = uarch_pkg::ROB_ENTRIES,
  parameter int PIPE_WIDTH  = uarch_pkg::PIPE_WIDTH,
  parameter int TAG_W       = $clog2(ROB_ENTRIES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIPE_WIDTH-1:0]            rob_we,
  output logic [PIPE_WIDTH-1:0]            rob_rdy,
  output logic [PIPE_WIDTH-1:0][TAG_W-1:0] alloc_tags,
  output logic [TAG_W-1:0]                 head_ptr,
  output logic [TAG_W-1:0]                 tail_ptr,
  output logic [TAG_W:0]                   rob_count,
  input  logic [PIPE_WIDTH-1:0]            head_done,
  input  logic [PIPE_WIDTH-1:0]            head_exc,
  output logic [PIPE_WIDTH-1:0]            commit_en,
  input  logic                             mispredict,
  input  logic [TAG_W-1:0]                 mispredict_tag,
  output logic                             flush_all,
  output logic [TAG_W-1:0]                 exc_tag
);

  rob_ctrl_state_e  state_q, state_d;
  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;
  logic [TAG_W-1:0] exc_tag_q, exc_tag_d;

  logic [TAG_W:0] count, free;
  logic [TAG_W:0] head_nxt, tail_nxt, tail_rec;
  logic [1:0]     rdy_raw, n_alloc, n_commit;
  logic           tag_ok, run, has1, has2;
  logic           exc_head, c0, c1;

  assign run  = (state_q == RUN) && !rst;
  assign has1 = count != '0;
  assign has2 = count >= (TAG_W+1)'(2);

  assign exc_head = has1 && head_done[0] && head_exc[0];
  assign c0 = run && has1 && head_done[0] && !head_exc[0];
  assign c1 = c0 && has2 && head_done[1] && !head_exc[1]
           && !(mispredict && head_q[TAG_W-1:0] == mispredict_tag);

  assign commit_en = {c1, c0};
  assign n_commit  = popcnt2(commit_en);
  assign n_alloc   = popcnt2(rob_we);

  rob_ptr_arith #(
    .ROB_ENTRIES(ROB_ENTRIES),
    .TAG_W      (TAG_W)
  ) u_arith (
    .head_i        (head_q),
    .tail_i        (tail_q),
    .n_commit_i    (n_commit),
    .n_alloc_i     (n_alloc),
    .tag_i         (mispredict_tag),
    .count_o       (count),
    .free_o        (free),
    .head_nxt_o    (head_nxt),
    .tail_nxt_o    (tail_nxt),
    .tail_rec_o    (tail_rec),
    .tag_in_range_o(tag_ok),
    .rdy_o         (rdy_raw)
  );

  assign rob_rdy   = run ? rdy_raw : 2'b00;
  assign flush_all = (state_q == EXC_FLUSH) && !rst;
  assign exc_tag   = rst ? '0 : exc_tag_q;
  assign head_ptr  = head_q[TAG_W-1:0];
  assign tail_ptr  = tail_q[TAG_W-1:0];
  assign rob_count = count;

  assign alloc_tags[0] = tail_q[TAG_W-1:0];
  assign alloc_tags[1] = tail_q[TAG_W-1:0] + TAG_W'(rob_we[0]);

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    exc_tag_d = exc_tag_q;
    unique case (state_q)
      RUN: begin
        priority case (1'b1)
          exc_head: begin
            state_d   = EXC_FLUSH;
            exc_tag_d = head_q[TAG_W-1:0];
            tail_d    = tail_nxt;
          end
          mispredict: begin
            state_d = RECOVER;
            head_d  = head_nxt;
            tail_d  = tail_rec;
          end
          default: begin
            head_d = head_nxt;
            tail_d = tail_nxt;
          end
        endcase
      end
      RECOVER: state_d = RUN;
      EXC_FLUSH: begin
        state_d = RUN;
        head_d  = '0;
        tail_d  = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      head_q    <= '0;
      tail_q    <= '0;
      exc_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      exc_tag_q <= exc_tag_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN) |-> ((TAG_W+1)'(n_alloc) <= free));

  a_tag_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN && mispredict && !exc_head) |-> tag_ok);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed vector table then random
// traffic against an occupancy-level reference model.
module tb_rob_alloc_ctrl;

  localparam int N  = 32;
  localparam int TW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rob_we, rob_rdy, head_done, head_exc, commit_en;
  logic [1:0][TW-1:0] alloc_tags;
  logic [TW-1:0]     head_ptr, tail_ptr, mispredict_tag, exc_tag;
  logic [TW:0]       rob_count;
  logic              mispredict, flush_all;

  always #5 clk = ~clk;

  rob_alloc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .rob_we        (rob_we),
    .rob_rdy       (rob_rdy),
    .alloc_tags    (alloc_tags),
    .head_ptr      (head_ptr),
    .tail_ptr      (tail_ptr),
    .rob_count     (rob_count),
    .head_done     (head_done),
    .head_exc      (head_exc),
    .commit_en     (commit_en),
    .mispredict    (mispredict),
    .mispredict_tag(mispredict_tag),
    .flush_all     (flush_all),
    .exc_tag       (exc_tag)
  );

  typedef struct {
    logic r; logic [1:0] we, dn, ex; logic mp; int tag;
    bit cp; int cnt, hd, tl, a0, a1;
    logic [1:0] rdy, com; logic fl; int et;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nmis = 0;

  // model: wrapped pointers in [0, 2N), state 0=run 1=recover 2=flush
  int mh = 0, mt = 0, mst = 0, met = 0;
  int e_cnt, e_ncom;
  logic [1:0] e_rdy, e_com;
  logic e_fl;

  function automatic vec_t mk(logic r, logic [1:0] we, dn, ex, logic mp,
      int tag, bit cp, int cnt, hd, tl, a0, a1,
      logic [1:0] rdy, com, logic fl, int et);
    vec_t v;
    v.r = r; v.we = we; v.dn = dn; v.ex = ex; v.mp = mp; v.tag = tag;
    v.cp = cp; v.cnt = cnt; v.hd = hd; v.tl = tl; v.a0 = a0; v.a1 = a1;
    v.rdy = rdy; v.com = com; v.fl = fl; v.et = et;
    return v;
  endfunction

  function automatic int pop2(logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  function automatic logic [1:0] model_rdy(logic r);
    int free;
    free = N - ((mt - mh + 2*N) % (2*N));
    if (r || mst != 0) return 2'b00;
    if (free >= 2) return 2'b11;
    if (free == 1) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(logic r, logic [1:0] we, dn, ex, logic mp, int tag);
    rst = r; rob_we = we; head_done = dn; head_exc = ex;
    mispredict = mp; mispredict_tag = TW'(tag);
  endtask

  task automatic model_eval();
    logic c0, c1;
    e_cnt = (mt - mh + 2*N) % (2*N);
    e_rdy = model_rdy(rst);
    c0 = !rst && mst == 0 && e_cnt >= 1 && head_done[0] && !head_exc[0];
    c1 = c0 && e_cnt >= 2 && head_done[1] && !head_exc[1]
         && !(mispredict && (mh % N) == int'(mispredict_tag));
    e_com  = {c1, c0};
    e_ncom = pop2(e_com);
    e_fl   = !rst && mst == 2;
  endtask

  task automatic model_update();
    int old;
    if (rst) begin
      mh = 0; mt = 0; mst = 0;
    end else if (mst == 0) begin
      if (e_cnt >= 1 && head_done[0] && head_exc[0]) begin
        mst = 2; met = mh % N;
        mt = (mt + pop2(rob_we)) % (2*N);
      end else if (mispredict) begin
        old = mh;
        mh = (mh + e_ncom) % (2*N);
        mt = (old + ((int'(mispredict_tag) - old % N + N) % N) + 1) % (2*N);
        mst = 1;
      end else begin
        mh = (mh + e_ncom) % (2*N);
        mt = (mt + pop2(rob_we)) % (2*N);
      end
    end else if (mst == 1) begin
      mst = 0;
    end else begin
      mh = 0; mt = 0; mst = 0;
    end
  endtask

  task automatic check(string nm, bit cp, int cnt, hd, tl, a0, a1,
      logic [1:0] rdy, com, logic fl, bit ce, int et);
    bit bad;
    bad = (rob_rdy !== rdy) || (commit_en !== com) || (flush_all !== fl);
    if (cp)
      bad = bad || (int'(rob_count) != cnt) || (int'(head_ptr) != hd)
            || (int'(tail_ptr) != tl) || (int'(alloc_tags[0]) != a0)
            || (int'(alloc_tags[1]) != a1);
    if (ce) bad = bad || (int'(exc_tag) != et);
    nvec++;
    if (bad) begin
      nmis++;
      $display("FAIL %s: got rdy=%b com=%b fl=%b cnt=%0d hd=%0d tl=%0d at=%0d,%0d etag=%0d; want rdy=%b com=%b fl=%b cnt=%0d hd=%0d tl=%0d at=%0d,%0d etag=%0d",
        nm, rob_rdy, commit_en, flush_all, rob_count, head_ptr, tail_ptr,
        alloc_tags[0], alloc_tags[1], exc_tag, rdy, com, fl, cnt, hd, tl,
        a0, a1, et);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    tbl.push_back(mk(1,0,0,0,0,0, 0, 0,0,0, 0,0, 2'b00,2'b00,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1, 0,0,0, 0,0, 2'b00,2'b00,0,0));
    for (int k = 0; k < 15; k++)
      tbl.push_back(mk(0,3,0,0,0,0, 1, 2*k,0,2*k, 2*k,2*k+1,
                       2'b11,2'b00,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1, 30,0,30, 30,31, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1, 31,0,31, 31,0, 2'b01,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 32,0,0, 0,0, 2'b00,2'b00,0,0));
    for (int k = 0; k < 15; k++)
      tbl.push_back(mk(0,0,3,0,0,0, 1, 32-2*k,2*k,0, 0,0,
                       (k == 0) ? 2'b00 : 2'b11, 2'b11,0,0));
    tbl.push_back(mk(0,3,0,0,0,0, 1, 2,30,0, 0,1, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,0,3,0,0,0, 1, 4,30,2, 2,2, 2'b11,2'b11,0,0));
    tbl.push_back(mk(0,0,3,0,0,0, 1, 2,0,2, 2,2, 2'b11,2'b11,0,0));
    tbl.push_back(mk(0,3,0,0,0,0, 1, 0,2,2, 2,3, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1, 2,2,4, 4,5, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,2,0,0,0,0, 1, 3,2,5, 5,5, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,3,0,0,0,0, 1, 4,2,6, 6,7, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,3,1,0,0,0, 1, 6,2,8, 8,9, 2'b11,2'b01,0,0));
    tbl.push_back(mk(0,3,3,0,1,3, 1, 7,3,10, 10,11, 2'b11,2'b01,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 0,4,4, 4,4, 2'b00,2'b00,0,0));
    tbl.push_back(mk(0,3,0,0,0,0, 1, 0,4,4, 4,5, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,3,0,0,0,0, 1, 2,4,6, 6,7, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,0,3,0,0,0, 1, 4,4,8, 8,8, 2'b11,2'b11,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 1, 2,6,8, 8,8, 2'b11,2'b01,0,0));
    tbl.push_back(mk(0,0,1,1,1,7, 1, 1,7,8, 8,8, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 1,7,8, 8,8, 2'b00,2'b00,1,7));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 0,0,0, 0,0, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 1, 0,0,0, 0,1, 2'b11,2'b00,0,0));
    tbl.push_back(mk(0,0,1,1,0,0, 1, 1,0,1, 1,1, 2'b11,2'b00,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1, 1,0,1, 1,1, 2'b00,2'b00,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 1, 0,0,0, 0,0, 2'b11,2'b00,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].we, tbl[i].dn, tbl[i].ex, tbl[i].mp, tbl[i].tag);
      #2;
      model_eval();
      check($sformatf("tbl[%0d]", i), tbl[i].cp, tbl[i].cnt, tbl[i].hd,
            tbl[i].tl, tbl[i].a0, tbl[i].a1, tbl[i].rdy, tbl[i].com,
            tbl[i].fl, tbl[i].fl || tbl[i].r, tbl[i].et);
      @(posedge clk);
      model_update();
      #1;
    end

    for (int i = 0; i < 800; i++) begin
      logic r, mp;
      logic [1:0] we, dn, ex, rdy;
      int cnt, tag;
      r   = (i == 0) || ($urandom_range(0, 149) == 0);
      rdy = model_rdy(r);
      cnt = (mt - mh + 2*N) % (2*N);
      we  = 2'b00;
      if (rdy == 2'b11) we = 2'($urandom_range(0, 3));
      else if (rdy == 2'b01) we = 2'($urandom_range(0, 2));
      dn  = 2'($urandom_range(0, 3));
      ex  = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mp  = 1'b0;
      tag = int'($urandom_range(0, N-1));
      if (!r && mst == 0 && cnt >= 1 && $urandom_range(0, 9) == 0) begin
        mp  = 1'b1;
        tag = (mh % N + int'($urandom_range(0, cnt-1))) % N;
      end
      drive(r, we, dn, ex, mp, tag);
      #2;
      model_eval();
      check($sformatf("rnd[%0d]", i), 1, e_cnt, mh % N, mt % N, mt % N,
            (mt + int'(we[0])) % N, e_rdy, e_com, e_fl,
            e_fl || r, r ? 0 : met);
      @(posedge clk);
      model_update();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
